// File: rtl/bit_serial_sub.sv
// bit_serial_sub: bit-serial subtractor computing a - b - bin over WIDTH bits.
// One full-subtractor cell is reused for WIDTH cycles, consuming operand bits
// LSB first and shifting result bits in from the MSB end. diff/bout are
// published only when the last bit completes and hold until the next result.
module bit_serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d_d;
    logic             nbr_d;
    logic [WIDTH-1:0] res_d;
    logic             last_d;

    // Full-subtractor cell on the current LSBs plus the next result word.
    always_comb begin
        d_d    = a_q[0] ^ b_q[0] ^ br_q;
        nbr_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d  = {d_d, res_q[WIDTH-1:1]};
        last_d = (cnt_q == CNT_LAST);
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= nbr_d;
                    res_q <= res_d;
                    if (last_d) begin
                        cnt_q   <= '0;
                        diff_q  <= res_d;
                        bout_q  <= nbr_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_bit_serial_sub.sv
// Testbench for bit_serial_sub: directed cases plus a random sweep, checked
// by a scoreboard that expects each result (value and done cycle) from an
// arithmetic reference model.
module tb_bit_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    bit_serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void bound_fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endfunction

    // Reference model: plain (W+1)-bit arithmetic; the top bit is the borrow.
    function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mbin,
                                   int unsigned done_cyc);
        exp_t        e;
        logic [W:0]  r;
        r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.d   = r[W-1:0];
        e.bo  = r[W];
        e.cyc = done_cyc;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever done is seen, flags missing results.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
            bound_fail("missing_done");
            void'(sb_q.pop_front());
        end
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                bound_fail("unexpected_done");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.bo));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) bound_fail("idle_wait");
    endtask

    task automatic wait_drain();
        int unsigned k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) bound_fail("drain_wait");
    endtask

    // Called at a negedge with the DUT idle; the next posedge accepts.
    task automatic issue(logic [W-1:0] ta, logic [W-1:0] tb, logic tbin, bit push);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        if (push) sb_q.push_back(model(ta, tb, tbin, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bc;
        int unsigned next_acc;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);

        // Start on the first edge after reset release; count busy cycles.
        rst = 1'b0;
        issue(8'h5A, 8'h3C, 1'b0, 1'b1);
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", bc, W + 1);
        wait_drain();

        wait_idle(); issue(8'h10, 8'h20, 1'b0, 1'b1);
        wait_idle(); issue(8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_idle(); issue(8'h00, 8'h00, 1'b1, 1'b1);
        wait_idle(); issue(8'h80, 8'h7F, 1'b1, 1'b1);
        wait_drain();
        wait_idle();

        // Start held high with operands changing every cycle: only the values
        // present on each accepting edge count, and accepts recur every W+2.
        start    = 1'b1;
        next_acc = cyc + 1;
        for (int i = 0; i < 42; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            if (cyc + 1 == next_acc) begin
                sb_q.push_back(model(a, b, bin, next_acc + W));
                next_acc = next_acc + W + 2;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();
        wait_idle();

        // Reset during the 4th RUN cycle aborts with no done pulse.
        issue(8'hC3, 8'h5A, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_bout", 32'(bout), 0);
        rst = 1'b0;
        issue(8'h37, 8'h73, 1'b0, 1'b1);
        wait_drain();

        // Random sweep.
        for (int n = 0; n < 1000; n++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        wait_drain();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
